hi_corr_mag_detect: RTL and testbench
=====================================

Name: hi_corr_mag_detect

Overview:
- Downstream consumer of the I/Q correlator output: one signed 8-bit I/Q pair every 64 adc_clk cycles.
- Computes an approximate subcarrier magnitude per pair and runs a hysteresis/debounce FSM to find tag response frames.
- Buffers in-frame magnitudes plus an end-of-frame marker in a small FIFO, drained by the SSP serializer through a valid/ready handshake.

Parameters:
- ON_COUNT, 2, consecutive pairs with mag >= thresh_hi required to enter a frame (1..15).
- OFF_COUNT, 4, consecutive pairs with mag < thresh_lo required to leave a frame (1..15).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2).

Ports:
- adc_clk  in  1  sole clock, all logic on negedge (matches correlator timing).
- nreset  in  1  asynchronous active-low reset.
- corr_valid  in  1  one-cycle strobe: corr_i/corr_q hold a new pair.
- corr_i  in  8  signed I correlation.
- corr_q  in  8  signed Q correlation.
- thresh_hi  in  8  unsigned entry threshold.
- thresh_lo  in  8  unsigned exit threshold (software guarantees thresh_lo <= thresh_hi).
- mag  out  8  last computed magnitude.
- mag_valid  out  1  one-cycle strobe, mag updated.
- frame_active  out  1  high while the FSM is in ACTIVE.
- sof  out  1  one-cycle pulse on entry to ACTIVE.
- out_data  out  9  FIFO head: {marker, value[7:0]}.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head this cycle.
- overflow  out  1  sticky: a push was dropped.
- ovf_clr  in  1  synchronous clear of overflow.

Behaviour:
- Reset (async, nreset=0): mag=0, mag_valid=0, frame_active=0, sof=0, out_valid=0, out_data=0, overflow=0; FIFO empty; FSM IDLE; counters 0. Takes effect immediately, including mid-frame. No marker is emitted for a frame cut by reset.
- Stage 1 (cycle after corr_valid): a=|corr_i|, b=|corr_q|. Abs of -128 = 128, computed in 9 bits. mag = max(a,b) + (min(a,b)>>1). Maximum is 192, so no saturation. mag_valid pulses for one cycle.
- Stage 2 (cycle after mag_valid): FSM step and FIFO push decision. out_valid rises the cycle after the push. Total latency corr_valid -> out_valid is 3 cycles with the FIFO empty.
- FSM states:
  - IDLE: mag >= thresh_hi -> cnt=1; then ACTIVE if ON_COUNT==1, else ARMED. Otherwise stay.
  - ARMED: mag >= thresh_hi -> cnt+1; on reaching ON_COUNT -> ACTIVE and pulse sof. mag < thresh_hi -> IDLE, cnt=0.
  - ACTIVE: frame_active=1; push {0,mag} on every mag_valid. mag < thresh_lo -> cnt+1, else cnt=0. When cnt reaches OFF_COUNT -> IDLE, and push marker {1,8'h00} instead of that pair's sample.
- The sample that completes ON_COUNT is the first one pushed. Earlier ARMED samples are discarded.
- At most one push per cycle by construction.
- FIFO:
  - Pop when out_valid & out_ready.
  - Push and pop in the same cycle are both honoured, including when full: the pop frees space and the push is accepted.
  - Push when full without a pop: data dropped, overflow set.
  - Pop when empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH. A full/empty extra bit distinguishes the two states.
- overflow: ovf_clr clears it. Clear and a simultaneous drop in the same cycle -> overflow stays 1 (set wins).
- mag_valid does not depend on the FSM; thresholds are sampled at stage 2.

Optional Feature:
- Macro: HI_CORR_MAG_L1_EN.
- Defined: mag = min(|I|+|Q|, 255), i.e. the L1 norm saturated to 8 bits.
- Undefined: max + min/2 approximation as above.
- Latency, FSM and FIFO behaviour are identical in both cases.

Test Plan:
- Reset, then I=40, Q=-20 strobe -> mag=50 with mag_valid one cycle later. I=-128, Q=-128 -> mag=192 (L1_EN: 255).
- thresh_hi=30, thresh_lo=15; pairs with mags 10, 35, 40 -> sof on the 40 pair, frame_active=1. FIFO holds only {0,40}; 35 is discarded.
- In ACTIVE feed mags 50, 10, 10, 20, 10, 10, 10, 10, out_ready=1 -> pushes 50, 10, 10, 20, 10, 10, 10, then marker 0x100. The cnt reset by 20 is verified, and frame_active falls with the marker push.
- out_ready=0 during a 6-sample frame with FIFO_DEPTH=4 -> 4 entries held, overflow=1. ovf_clr pulse -> 0. Subsequent pops return the first 4 samples in order.
- Full FIFO plus simultaneous push and pop -> no drop, overflow stays 0, count stays 4.
- nreset asserted mid-frame with 3 entries queued -> all outputs 0 immediately. A new frame after release starts from IDLE with no stale marker.

Source files
------------

// File: rtl/hi_corr_mag_detect.sv
// Magnitude detector, hysteresis frame finder and output FIFO for the I/Q correlator stream.
// Define HI_CORR_MAG_L1_EN to use the saturated L1 norm instead of the max + min/2 estimate.
module hi_corr_mag_detect #(
  parameter int ON_COUNT   = 2,
  parameter int OFF_COUNT  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       adc_clk,
  input  logic       nreset,
  input  logic       corr_valid,
  input  logic [7:0] corr_i,
  input  logic [7:0] corr_q,
  input  logic [7:0] thresh_hi,
  input  logic [7:0] thresh_lo,
  output logic [7:0] mag,
  output logic       mag_valid,
  output logic       frame_active,
  output logic       sof,
  output logic [8:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow,
  input  logic       ovf_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0] LP_ON  = 4'(ON_COUNT);
  localparam logic [3:0] LP_OFF = 4'(OFF_COUNT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARMED  = 2'd1;
  localparam logic [1:0] S_ACTIVE = 2'd2;

  logic [8:0] w_abs_i;
  logic [8:0] w_abs_q;
  logic [9:0] w_sum;
  logic [7:0] w_mag_nx;

  // Abs in 9 bits so that -128 maps to 128.
  assign w_abs_i = corr_i[7] ? (9'd0 - {corr_i[7], corr_i}) : {1'b0, corr_i};
  assign w_abs_q = corr_q[7] ? (9'd0 - {corr_q[7], corr_q}) : {1'b0, corr_q};

`ifdef HI_CORR_MAG_L1_EN
  assign w_sum = {1'b0, w_abs_i} + {1'b0, w_abs_q};
`else
  logic [8:0] w_max;
  logic [8:0] w_min;
  assign w_max = (w_abs_i >= w_abs_q) ? w_abs_i : w_abs_q;
  assign w_min = (w_abs_i >= w_abs_q) ? w_abs_q : w_abs_i;
  assign w_sum = {1'b0, w_max} + {1'b0, (w_min >> 1)};
`endif

  // The approximation tops out at 192, so the clamp only ever acts on the L1 sum.
  assign w_mag_nx = (w_sum > 10'd255) ? 8'hFF : w_sum[7:0];

  logic [7:0] r_mag;
  logic       r_mag_valid;

  always_ff @(negedge adc_clk or negedge nreset) begin
    if (!nreset) begin
      r_mag       <= 8'd0;
      r_mag_valid <= 1'b0;
    end else begin
      r_mag_valid <= corr_valid;
      if (corr_valid) r_mag <= w_mag_nx;
    end
  end

  assign mag       = r_mag;
  assign mag_valid = r_mag_valid;

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       r_push;
  logic [8:0] r_push_data;
  logic       r_sof;
  logic [1:0] w_state_nx;
  logic [3:0] w_cnt_nx;
  logic       w_push_nx;
  logic [8:0] w_push_data_nx;
  logic       w_sof_nx;

  // r_cnt counts entry hits while arming and exit misses while active.
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_push_nx      = 1'b0;
    w_push_data_nx = {1'b0, r_mag};
    w_sof_nx       = 1'b0;
    if (r_mag_valid) begin
      case (r_state)
        S_IDLE: begin
          if (r_mag >= thresh_hi) begin
            if (LP_ON == 4'd1) begin
              w_state_nx = S_ACTIVE;
              w_cnt_nx   = 4'd0;
              w_sof_nx   = 1'b1;
              w_push_nx  = 1'b1;
            end else begin
              w_state_nx = S_ARMED;
              w_cnt_nx   = 4'd1;
            end
          end
        end
        S_ARMED: begin
          if (r_mag >= thresh_hi) begin
            if ((r_cnt + 4'd1) == LP_ON) begin
              w_state_nx = S_ACTIVE;
              w_cnt_nx   = 4'd0;
              w_sof_nx   = 1'b1;
              w_push_nx  = 1'b1;
            end else begin
              w_cnt_nx = r_cnt + 4'd1;
            end
          end else begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = 4'd0;
          end
        end
        S_ACTIVE: begin
          w_push_nx = 1'b1;
          if (r_mag < thresh_lo) begin
            if ((r_cnt + 4'd1) == LP_OFF) begin
              w_state_nx     = S_IDLE;
              w_cnt_nx       = 4'd0;
              w_push_data_nx = 9'h100;
            end else begin
              w_cnt_nx = r_cnt + 4'd1;
            end
          end else begin
            w_cnt_nx = 4'd0;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(negedge adc_clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_push      <= 1'b0;
      r_push_data <= 9'd0;
      r_sof       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_push      <= w_push_nx;
      r_push_data <= w_push_data_nx;
      r_sof       <= w_sof_nx;
    end
  end

  assign frame_active = (r_state == S_ACTIVE);
  assign sof          = r_sof;

  logic [8:0]  r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        r_overflow;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_wr_en;
  logic        w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = !w_empty && out_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO can still take the push.
  assign w_wr_en = r_push && (!w_full || w_pop);
  assign w_drop  = r_push && w_full && !w_pop;

  always_ff @(negedge adc_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= r_push_data;
  end

  always_ff @(negedge adc_clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)   r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, 1'b1};
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign out_valid = !w_empty;
  assign out_data  = w_empty ? 9'd0 : r_mem[r_rd_ptr[AW-1:0]];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_hi_corr_mag_detect.sv
// Table-driven bench for hi_corr_mag_detect with a queue scoreboard on the FIFO output.
// Expected magnitudes follow HI_CORR_MAG_L1_EN when it is defined.
module tb_hi_corr_mag_detect;

  logic       adc_clk = 1'b0;
  logic       nreset;
  logic       corr_valid;
  logic [7:0] corr_i;
  logic [7:0] corr_q;
  logic [7:0] thresh_hi;
  logic [7:0] thresh_lo;
  logic [7:0] mag;
  logic       mag_valid;
  logic       frame_active;
  logic       sof;
  logic [8:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       overflow;
  logic       ovf_clr;

  int nChecks  = 0;
  int nFail    = 0;
  int popCount = 0;
  logic [8:0] sb[$];

  typedef struct {
    logic signed [7:0] i;
    logic signed [7:0] q;
    logic              sof;
    logic              act;
    logic              push;
    logic [8:0]        data;
    logic              ovf;
  } vec_t;

  vec_t vecs[$];

  hi_corr_mag_detect dut (
    .adc_clk      (adc_clk),
    .nreset       (nreset),
    .corr_valid   (corr_valid),
    .corr_i       (corr_i),
    .corr_q       (corr_q),
    .thresh_hi    (thresh_hi),
    .thresh_lo    (thresh_lo),
    .mag          (mag),
    .mag_valid    (mag_valid),
    .frame_active (frame_active),
    .sof          (sof),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 adc_clk = ~adc_clk;

  function automatic int refMag(input int i, input int q);
    int a;
    int b;
    a = (i < 0) ? -i : i;
    b = (q < 0) ? -q : q;
`ifdef HI_CORR_MAG_L1_EN
    return ((a + b) > 255) ? 255 : (a + b);
`else
    return ((a > b) ? a : b) + (((a > b) ? b : a) / 2);
`endif
  endfunction

  function automatic vec_t mk(input int i, input int q, input bit s, input bit act,
                              input bit push, input int data, input bit ovf);
    vec_t v;
    v.i    = 8'(i);
    v.q    = 8'(q);
    v.sof  = s;
    v.act  = act;
    v.push = push;
    v.data = 9'(data);
    v.ovf  = ovf;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Inputs for the coming negedge are already set; log a handshake pop, then advance.
  task automatic cycle();
    logic [8:0] exp;
    if (out_valid && out_ready) begin
      popCount++;
      if (sb.size() == 0) begin
        nChecks++;
        nFail++;
        $display("[TB] FAIL fifo pop: got 0x%0h, expected no output", out_data);
      end else begin
        exp = sb.pop_front();
        checkOutput("fifo data", int'(out_data), int'(exp));
      end
    end
    @(posedge adc_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic signed [7:0] i, input logic signed [7:0] q);
    corr_i     = i;
    corr_q     = q;
    corr_valid = 1'b1;
  endtask

  task automatic checkMagPair(input logic signed [7:0] i, input logic signed [7:0] q,
                              input int expected);
    applyStimulus(i, q);
    cycle();
    checkOutput("mag_valid pulse", int'(mag_valid), 1);
    checkOutput($sformatf("mag(%0d,%0d)", i, q), int'(mag), expected);
    corr_valid = 1'b0;
    cycle();
    checkOutput("mag_valid one cycle", int'(mag_valid), 0);
    cycle();
    cycle();
  endtask

  task automatic runVec(input vec_t v, input int idx);
    if (v.push) sb.push_back(v.data);
    applyStimulus(v.i, v.q);
    cycle();
    checkOutput($sformatf("vec%0d mag_valid", idx), int'(mag_valid), 1);
    checkOutput($sformatf("vec%0d mag", idx), int'(mag), refMag(int'(v.i), int'(v.q)));
    corr_valid = 1'b0;
    cycle();
    checkOutput($sformatf("vec%0d sof", idx), int'(sof), int'(v.sof));
    checkOutput($sformatf("vec%0d frame_active", idx), int'(frame_active), int'(v.act));
    cycle();
    checkOutput($sformatf("vec%0d overflow", idx), int'(overflow), int'(v.ovf));
    checkOutput($sformatf("vec%0d sof width", idx), int'(sof), 0);
    cycle();
  endtask

  task automatic drainAll(input int expected);
    int start;
    int budget;
    start     = popCount;
    budget    = 0;
    out_ready = 1'b1;
    while (out_valid && budget < 20) begin
      cycle();
      budget++;
    end
    if (budget >= 20) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL drain timeout: out_valid still 1 after %0d cycles", budget);
    end
    checkOutput("drain count", popCount - start, expected);
  endtask

  initial begin
    nreset     = 1'b1;
    corr_valid = 1'b0;
    corr_i     = 8'd0;
    corr_q     = 8'd0;
    thresh_hi  = 8'hFF;
    thresh_lo  = 8'h00;
    out_ready  = 1'b0;
    ovf_clr    = 1'b0;

    // Frame entry with an aborted arm, then cnt restart by 20 and a clean exit.
    vecs.push_back(mk( 35,   0, 0, 0, 0, 'h000, 0));
    vecs.push_back(mk( 12,   0, 0, 0, 0, 'h000, 0));
    vecs.push_back(mk(  0, -10, 0, 0, 0, 'h000, 0));
    vecs.push_back(mk(-35,   0, 0, 0, 0, 'h000, 0));
    vecs.push_back(mk( 40,   0, 1, 1, 1, 'h028, 0));
    vecs.push_back(mk(  0,  50, 0, 1, 1, 'h032, 0));
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk(-10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 20,   0, 0, 1, 1, 'h014, 0));
    vecs.push_back(mk(  0,  10, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk(  0, -10, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 10,   0, 0, 0, 1, 'h100, 0));
    vecs.push_back(mk( 10,   0, 0, 0, 0, 'h000, 0));
    // 14..19: consumer stalled, entry exactly at thresh_hi, fifth sample dropped.
    vecs.push_back(mk( 30,   0, 0, 0, 0, 'h000, 0));
    vecs.push_back(mk(  0, -30, 1, 1, 1, 'h01E, 0));
    vecs.push_back(mk( 15,   0, 0, 1, 1, 'h00F, 0));
    vecs.push_back(mk( 50,   0, 0, 1, 1, 'h032, 0));
    vecs.push_back(mk(-60,   0, 0, 1, 1, 'h03C, 0));
    vecs.push_back(mk( 70,   0, 0, 1, 0, 'h000, 1));
    // 20..27: a sample equal to thresh_lo restarts the exit count.
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk(  0,  10, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk(-10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 15,   0, 0, 1, 1, 'h00F, 0));
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 10,   0, 0, 0, 1, 'h100, 0));
    // 28..32: fill the FIFO to exactly full.
    vecs.push_back(mk( 40,   0, 0, 0, 0, 'h000, 0));
    vecs.push_back(mk( 40,   0, 1, 1, 1, 'h028, 0));
    vecs.push_back(mk( 41,   0, 0, 1, 1, 'h029, 0));
    vecs.push_back(mk( 42,   0, 0, 1, 1, 'h02A, 0));
    vecs.push_back(mk( 43,   0, 0, 1, 1, 'h02B, 0));
    // 33..35: three entries queued before a mid-frame reset.
    vecs.push_back(mk( 45,   0, 0, 1, 1, 'h02D, 0));
    vecs.push_back(mk( 46,   0, 0, 1, 1, 'h02E, 0));
    vecs.push_back(mk( 47,   0, 0, 1, 1, 'h02F, 0));
    // 36..41: fresh frame after reset must arm from IDLE.
    vecs.push_back(mk( 35,   0, 0, 0, 0, 'h000, 0));
    vecs.push_back(mk( 40,   0, 1, 1, 1, 'h028, 0));
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 10,   0, 0, 1, 1, 'h00A, 0));
    vecs.push_back(mk( 10,   0, 0, 0, 1, 'h100, 0));

    #2 nreset = 1'b0;
    repeat (2) @(posedge adc_clk);
    #1;
    checkOutput("reset mag", int'(mag), 0);
    checkOutput("reset mag_valid", int'(mag_valid), 0);
    checkOutput("reset frame_active", int'(frame_active), 0);
    checkOutput("reset sof", int'(sof), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset out_data", int'(out_data), 0);
    checkOutput("reset overflow", int'(overflow), 0);
    nreset = 1'b1;
    cycle();
    cycle();

`ifdef HI_CORR_MAG_L1_EN
    checkMagPair(-8'sd128, -8'sd128, 255);
`else
    checkMagPair(-8'sd128, -8'sd128, 192);
`endif
    for (int k = 0; k < 8; k++) begin
      int ri;
      int rq;
      ri = int'($urandom_range(200)) - 100;
      rq = int'($urandom_range(200)) - 100;
      checkMagPair(8'(ri), 8'(rq), refMag(ri, rq));
    end
`ifdef HI_CORR_MAG_L1_EN
    checkMagPair(8'sd40, -8'sd20, 60);
`else
    checkMagPair(8'sd40, -8'sd20, 50);
`endif
    checkMagPair(8'sd0, 8'sd0, 0);

    thresh_hi = 8'd30;
    thresh_lo = 8'd15;
    out_ready = 1'b1;
    for (int k = 0; k <= 13; k++) runVec(vecs[k], k);
    checkOutput("scoreboard empty after frame", sb.size(), 0);

    out_ready = 1'b0;
    for (int k = 14; k <= 19; k++) runVec(vecs[k], k);
    // Second drop lands in the same cycle as ovf_clr; the set must win.
    applyStimulus(8'sd80, 8'sd0);
    cycle();
    corr_valid = 1'b0;
    cycle();
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    checkOutput("overflow set beats clear", int'(overflow), 1);
    checkOutput("fifo full out_valid", int'(out_valid), 1);
    ovf_clr = 1'b1;
    cycle();
    ovf_clr = 1'b0;
    checkOutput("overflow cleared", int'(overflow), 0);
    drainAll(4);

    out_ready = 1'b1;
    for (int k = 20; k <= 27; k++) runVec(vecs[k], k);
    checkOutput("scoreboard empty after exit", sb.size(), 0);

    out_ready = 1'b0;
    for (int k = 28; k <= 32; k++) runVec(vecs[k], k);
    // Push and pop together into a full FIFO: nothing lost, depth stays 4.
    sb.push_back(9'h02C);
    applyStimulus(8'sd44, 8'sd0);
    cycle();
    corr_valid = 1'b0;
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    checkOutput("full push+pop overflow", int'(overflow), 0);
    checkOutput("full push+pop out_valid", int'(out_valid), 1);
    drainAll(4);

    out_ready = 1'b0;
    for (int k = 33; k <= 35; k++) runVec(vecs[k], k);
    checkOutput("pre-reset frame_active", int'(frame_active), 1);
    checkOutput("pre-reset out_valid", int'(out_valid), 1);
    nreset = 1'b0;
    #1;
    checkOutput("async reset mag", int'(mag), 0);
    checkOutput("async reset frame_active", int'(frame_active), 0);
    checkOutput("async reset sof", int'(sof), 0);
    checkOutput("async reset out_valid", int'(out_valid), 0);
    checkOutput("async reset out_data", int'(out_data), 0);
    checkOutput("async reset overflow", int'(overflow), 0);
    sb.delete();
    cycle();
    cycle();
    nreset    = 1'b1;
    out_ready = 1'b1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      checkOutput("no stale marker", int'(out_valid), 0);
      cycle();
    end
    for (int k = 36; k <= 41; k++) runVec(vecs[k], k);
    drainAll(0);
    checkOutput("scoreboard empty at end", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
